pwm_duty_ramp_ctrl: RTL and testbench
=====================================

// Module: pwm_duty_ramp_ctrl
// PURPOSE
//  Soft-start/soft-stop sequencer for the PWM generator. Drives the generator's duty_cycle
//  input and walks it from its current value to a commanded target in programmable steps.
//  Duty changes only on PWM period boundaries (period_tick), so no mid-period duty glitches.
//  Sits between the control/register logic and the PWM generator.
// PARAMETERS
//  CNT_BITS   8   width of the PWM counter; duty is CNT_BITS+1 wide, MAX = 2**CNT_BITS = 100%
//  RATE_BITS  8   width of rate_div (period ticks per step - 1)
// PORTS
//  clk          in   1           system clock; all logic on posedge clk
//  reset_n      in   1           reset, synchronous, active-low
//  start        in   1           1-cycle pulse; begin ramp to target_duty (sampled in IDLE only)
//  abort        in   1           stop ramp, freeze duty_cycle at current value
//  target_duty  in   CNT_BITS+1  requested final duty; values > MAX clipped to MAX
//  step         in   CNT_BITS+1  duty increment per step; 0 treated as 1
//  rate_div     in   RATE_BITS   steps occur every rate_div+1 period_ticks
//  period_tick  in   1           1-cycle pulse at each PWM period wrap
//  duty_cycle   out  CNT_BITS+1  duty value to the PWM generator (registered)
//  busy         out  1           high while in RAMP_UP/RAMP_DN
//  done         out  1           1-cycle pulse when duty_cycle reaches target
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, duty_cycle=0, busy=0, done=0, tick_cnt=0,
//    latched target/step/rate=0. Reset mid-ramp takes effect the same edge, no done.
//  States: IDLE, RAMP_UP, RAMP_DN. busy = (state != IDLE), registered.
//  IDLE: on start=1 (abort=0): latch tgt=min(target_duty,MAX), stp=max(step,1),
//    rate=rate_div, tick_cnt=0.
//    tgt > duty_cycle -> RAMP_UP; tgt < duty_cycle -> RAMP_DN;
//    tgt == duty_cycle -> stay IDLE, done=1 next cycle.
//  start in cycle N -> busy=1 in cycle N+1. start while busy: ignored.
//  RAMP_*: on each period_tick: tick_cnt==rate -> tick_cnt=0 and apply step;
//    otherwise tick_cnt+1. A tick in the same cycle as the accepted start is not counted.
//  Step arithmetic uses CNT_BITS+2 bits (no overflow/underflow):
//    UP: duty+stp >= tgt -> duty=tgt, IDLE, done; else duty=duty+stp.
//    DN: duty <= tgt+stp -> duty=tgt, IDLE, done; else duty=duty-stp.
//  done is registered: high in the same cycle duty_cycle first shows tgt, low next cycle.
//    busy falls in that same cycle.
//  abort=1 in RAMP_*: next cycle IDLE, duty frozen, tick_cnt=0, no done.
//    abort outranks a simultaneous period_tick (no step) and a simultaneous start
//    (start dropped). abort in IDLE: no effect.
//  Inputs other than start/abort/period_tick are used only when latched at start;
//    later changes do not affect the ramp in progress.
//  duty_cycle==MAX is legal (100% duty); duty never exceeds MAX, never below 0.
// TESTING  (CNT_BITS=8)
//  1 Reset: reset_n=0 for 2 clks mid-ramp -> duty_cycle=0, busy=0, done=0, no done pulse.
//  2 Up: duty=0, start tgt=100 stp=30 rate=0, 4 ticks -> duty 30,60,90,100;
//    done pulse with 100; busy=0.
//  3 Down: duty=100, start tgt=10 stp=40 rate=2, 9 ticks -> duty changes only on
//    ticks 3,6,9: 60,20,10; done at 10.
//  4 Clip/zero step: duty=0, start tgt=300 stp=200 rate=0 -> 200, 256 (MAX), done.
//    Then start tgt=255 stp=0 -> 255 after 1 tick.
//  5 Abort: mid-ramp at duty=60, abort coincident with period_tick -> duty stays 60,
//    busy=0, no done. Then start tgt=60 -> done next cycle, busy never 1.
//  6 Start during ramp: second start with tgt=0 while ramping up to 100 -> ignored,
//    ramp completes at 100.

Source files
------------

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Control/status bundle between the register logic and the duty ramp sequencer.
// The master drives the ramp commands and the period tick; the slave returns duty and status.
interface pwm_duty_ramp_ctrl_if #(
    parameter int unsigned CNT_BITS  = 8,
    parameter int unsigned RATE_BITS = 8
) ();
    logic                 start;
    logic                 abort;
    logic [CNT_BITS:0]    target_duty;
    logic [CNT_BITS:0]    step;
    logic [RATE_BITS-1:0] rate_div;
    logic                 period_tick;
    logic [CNT_BITS:0]    duty_cycle;
    logic                 busy;
    logic                 done;

    modport master (
        output start, abort, target_duty, step, rate_div, period_tick,
        input  duty_cycle, busy, done
    );

    modport slave (
        input  start, abort, target_duty, step, rate_div, period_tick,
        output duty_cycle, busy, done
    );
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: walks the PWM duty toward a target in steps,
// updating only on PWM period boundaries.
module pwm_duty_ramp_ctrl #(
    parameter int unsigned CNT_BITS  = 8,
    parameter int unsigned RATE_BITS = 8
) (
    input logic                   i_clk,
    input logic                   i_reset_n,
    pwm_duty_ramp_ctrl_if.slave   bus
);
    localparam logic [CNT_BITS:0] DUTY_MAX = {1'b1, {CNT_BITS{1'b0}}};
    localparam logic [CNT_BITS:0] STEP_ONE = {{CNT_BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRampUp, StRampDn} state_e;

    state_e               r_state,    w_state_d;
    logic [CNT_BITS:0]    r_duty,     w_duty_d;
    logic [CNT_BITS:0]    r_tgt,      w_tgt_d;
    logic [CNT_BITS:0]    r_stp,      w_stp_d;
    logic [RATE_BITS-1:0] r_rate,     w_rate_d;
    logic [RATE_BITS-1:0] r_tick_cnt, w_tick_cnt_d;
    logic                 r_busy,     w_busy_d;
    logic                 r_done,     w_done_d;

    logic [CNT_BITS:0]    w_tgt_clip;
    logic [CNT_BITS:0]    w_stp_fix;
    // One extra bit so the step comparisons can neither overflow nor underflow.
    logic [CNT_BITS+1:0]  w_duty_plus;
    logic [CNT_BITS+1:0]  w_tgt_plus;
    logic                 w_step_now;

    assign w_tgt_clip  = (bus.target_duty > DUTY_MAX) ? DUTY_MAX : bus.target_duty;
    assign w_stp_fix   = (bus.step == '0) ? STEP_ONE : bus.step;
    assign w_duty_plus = {1'b0, r_duty} + {1'b0, r_stp};
    assign w_tgt_plus  = {1'b0, r_tgt} + {1'b0, r_stp};
    assign w_step_now  = bus.period_tick && (r_tick_cnt == r_rate);

    always_comb begin
        w_state_d    = r_state;
        w_duty_d     = r_duty;
        w_tgt_d      = r_tgt;
        w_stp_d      = r_stp;
        w_rate_d     = r_rate;
        w_tick_cnt_d = r_tick_cnt;
        w_done_d     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    w_tgt_d      = w_tgt_clip;
                    w_stp_d      = w_stp_fix;
                    w_rate_d     = bus.rate_div;
                    w_tick_cnt_d = '0;
                    if (w_tgt_clip > r_duty) begin
                        w_state_d = StRampUp;
                    end else if (w_tgt_clip < r_duty) begin
                        w_state_d = StRampDn;
                    end else begin
                        w_done_d = 1'b1;
                    end
                end
            end
            StRampUp, StRampDn: begin
                if (bus.abort) begin
                    w_state_d    = StIdle;
                    w_tick_cnt_d = '0;
                end else if (bus.period_tick && !w_step_now) begin
                    w_tick_cnt_d = r_tick_cnt + RATE_BITS'(1);
                end else if (w_step_now) begin
                    w_tick_cnt_d = '0;
                    if (r_state == StRampUp) begin
                        if (w_duty_plus >= {1'b0, r_tgt}) begin
                            w_duty_d  = r_tgt;
                            w_state_d = StIdle;
                            w_done_d  = 1'b1;
                        end else begin
                            w_duty_d = w_duty_plus[CNT_BITS:0];
                        end
                    end else begin
                        if ({1'b0, r_duty} <= w_tgt_plus) begin
                            w_duty_d  = r_tgt;
                            w_state_d = StIdle;
                            w_done_d  = 1'b1;
                        end else begin
                            w_duty_d = r_duty - r_stp;
                        end
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= StIdle;
            r_duty     <= '0;
            r_tgt      <= '0;
            r_stp      <= '0;
            r_rate     <= '0;
            r_tick_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_duty     <= w_duty_d;
            r_tgt      <= w_tgt_d;
            r_stp      <= w_stp_d;
            r_rate     <= w_rate_d;
            r_tick_cnt <= w_tick_cnt_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
        end
    end

    assign bus.duty_cycle = r_duty;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for the duty ramp sequencer with hand-computed expectations.
module tb_pwm_duty_ramp_ctrl;
    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    pwm_duty_ramp_ctrl_if #(.CNT_BITS(8), .RATE_BITS(8)) bus ();

    pwm_duty_ramp_ctrl #(.CNT_BITS(8), .RATE_BITS(8)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int tgt, input int stp, input int rate);
        bus.target_duty = 9'(tgt);
        bus.step        = 9'(stp);
        bus.rate_div    = 8'(rate);
        bus.start       = 1'b1;
        cyc();
        bus.start       = 1'b0;
    endtask

    task automatic do_tick();
        bus.period_tick = 1'b1;
        cyc();
        bus.period_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        checks++; if (bus.duty_cycle !== 9'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", bus.duty_cycle); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        reset_n = 1'b1;
        cyc();
        do_start(100, 30, 0);
        do_tick();
        do_tick();
        do_tick();
        checks++; if (bus.duty_cycle !== 9'd90) begin errors++; $display("FAIL reset_preramp: got %0d want 90", bus.duty_cycle); end
        // Reset lands on the tick that would have finished the ramp.
        reset_n = 1'b0;
        bus.period_tick = 1'b1;
        cyc();
        bus.period_tick = 1'b0;
        checks++; if (bus.duty_cycle !== 9'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_midramp: got duty=%0d busy=%b done=%b want 0/0/0", bus.duty_cycle, bus.busy, bus.done); end
        cyc();
        reset_n = 1'b1;
        cyc();
        checks++; if (bus.duty_cycle !== 9'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_release: got duty=%0d busy=%b done=%b want 0/0/0", bus.duty_cycle, bus.busy, bus.done); end
    endtask

    task automatic test_up();
        int exp_duty [4] = '{30, 60, 90, 100};
        do_start(100, 30, 0);
        checks++; if (bus.busy !== 1'b1 || bus.duty_cycle !== 9'd0) begin
            errors++; $display("FAIL up_start: got busy=%b duty=%0d want 1/0", bus.busy, bus.duty_cycle); end
        for (int i = 0; i < 4; i++) begin
            do_tick();
            checks++; if (bus.duty_cycle !== 9'(exp_duty[i])) begin
                errors++; $display("FAIL up_duty%0d: got %0d want %0d", i, bus.duty_cycle, exp_duty[i]); end
            checks++; if (bus.done !== (i == 3) || bus.busy !== (i != 3)) begin
                errors++; $display("FAIL up_status%0d: got done=%b busy=%b want %b/%b", i, bus.done, bus.busy, i == 3, i != 3); end
        end
        cyc();
        checks++; if (bus.done !== 1'b0 || bus.duty_cycle !== 9'd100) begin
            errors++; $display("FAIL up_after: got done=%b duty=%0d want 0/100", bus.done, bus.duty_cycle); end
    endtask

    task automatic test_down();
        int exp_d;
        do_start(10, 40, 2);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL dn_start_busy: got %b want 1", bus.busy); end
        for (int t = 1; t <= 9; t++) begin
            do_tick();
            exp_d = (t < 3) ? 100 : (t < 6) ? 60 : (t < 9) ? 20 : 10;
            checks++; if (bus.duty_cycle !== 9'(exp_d) || bus.done !== (t == 9)) begin
                errors++; $display("FAIL dn_tick%0d: got duty=%0d done=%b want %0d/%b", t, bus.duty_cycle, bus.done, exp_d, t == 9); end
        end
        cyc();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL dn_after: got done=%b busy=%b want 0/0", bus.done, bus.busy); end
    endtask

    task automatic test_clip();
        do_reset();
        // Tick coincident with the accepted start must not count.
        bus.target_duty = 9'd300;
        bus.step        = 9'd200;
        bus.rate_div    = 8'd0;
        bus.start       = 1'b1;
        bus.period_tick = 1'b1;
        cyc();
        bus.start       = 1'b0;
        bus.period_tick = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.duty_cycle !== 9'd0) begin
            errors++; $display("FAIL clip_start: got busy=%b duty=%0d want 1/0", bus.busy, bus.duty_cycle); end
        do_tick();
        checks++; if (bus.duty_cycle !== 9'd200 || bus.done !== 1'b0) begin
            errors++; $display("FAIL clip_t1: got duty=%0d done=%b want 200/0", bus.duty_cycle, bus.done); end
        do_tick();
        checks++; if (bus.duty_cycle !== 9'd256 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL clip_max: got duty=%0d done=%b busy=%b want 256/1/0", bus.duty_cycle, bus.done, bus.busy); end
        do_start(255, 0, 0);
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL zstep_start: got busy=%b done=%b want 1/0", bus.busy, bus.done); end
        do_tick();
        checks++; if (bus.duty_cycle !== 9'd255 || bus.done !== 1'b1) begin
            errors++; $display("FAIL zstep_t1: got duty=%0d done=%b want 255/1", bus.duty_cycle, bus.done); end
    endtask

    task automatic test_abort();
        do_reset();
        do_start(100, 30, 0);
        do_tick();
        do_tick();
        checks++; if (bus.duty_cycle !== 9'd60) begin errors++; $display("FAIL abort_pre: got %0d want 60", bus.duty_cycle); end
        bus.abort       = 1'b1;
        bus.period_tick = 1'b1;
        cyc();
        bus.abort       = 1'b0;
        bus.period_tick = 1'b0;
        checks++; if (bus.duty_cycle !== 9'd60 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL abort_hit: got duty=%0d busy=%b done=%b want 60/0/0", bus.duty_cycle, bus.busy, bus.done); end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        checks++; if (bus.duty_cycle !== 9'd60 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got duty=%0d busy=%b done=%b want 60/0/0", bus.duty_cycle, bus.busy, bus.done); end
        do_start(60, 30, 0);
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.duty_cycle !== 9'd60) begin
            errors++; $display("FAIL same_tgt: got done=%b busy=%b duty=%0d want 1/0/60", bus.done, bus.busy, bus.duty_cycle); end
        cyc();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL same_tgt_after: got done=%b busy=%b want 0/0", bus.done, bus.busy); end
    endtask

    task automatic test_back_to_back();
        int exp_duty [3] = '{60, 90, 100};
        do_reset();
        do_start(100, 30, 0);
        do_tick();
        do_start(0, 30, 0);
        checks++; if (bus.busy !== 1'b1 || bus.duty_cycle !== 9'd30) begin
            errors++; $display("FAIL b2b_ignored: got busy=%b duty=%0d want 1/30", bus.busy, bus.duty_cycle); end
        for (int i = 0; i < 3; i++) begin
            do_tick();
            checks++; if (bus.duty_cycle !== 9'(exp_duty[i]) || bus.done !== (i == 2)) begin
                errors++; $display("FAIL b2b_t%0d: got duty=%0d done=%b want %0d/%b", i, bus.duty_cycle, bus.done, exp_duty[i], i == 2); end
        end
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.target_duty = '0;
        bus.step        = '0;
        bus.rate_div    = '0;
        bus.period_tick = 1'b0;
        #1;
        test_reset();
        test_up();
        test_down();
        test_clip();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
